// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory access controller: state encoding, control-output bundle and
// the default timeout. The timeout feature itself is enabled with MEM_TIMEOUT_EN.
package mem_ctrl_pkg;

    localparam int unsigned TimeoutCyclesDefault = 16;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StRdWait,
        StRdLatch,
        StWrWait,
        StDone
    } state_e;

    typedef struct packed {
        logic mar_in;
        logic mdr_in;
        logic read;
        logic write;
        logic mem_en;
        logic busy;
        logic done;
    } ctrl_t;

    // Control outputs that belong to a given state.
    function automatic ctrl_t decode_ctrl(state_e s);
        ctrl_t c;
        c      = '0;
        c.busy = (s != StIdle);
        case (s)
            StAddr:    c.mar_in = 1'b1;
            StRdWait:  begin c.read = 1'b1; c.mem_en = 1'b1; end
            StRdLatch: begin c.read = 1'b1; c.mdr_in = 1'b1; c.mem_en = 1'b1; end
            StWrWait:  begin c.write = 1'b1; c.mem_en = 1'b1; end
            StDone:    c.done = 1'b1;
            default:   ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter for the memory access controller; only instantiated when
// MEM_TIMEOUT_EN is defined.
module wait_timer
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;

    assign expired = count_en && (count_q == LastCount);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= 8'd0;
        end else if (clear) begin
            count_q <= 8'd0;
        end else if (count_en && !expired) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: MAR load, read/write wait states, MDR latch and done pulse.
// Define MEM_TIMEOUT_EN to abort wait states after TIMEOUT_CYCLES cycles with err.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic clk,
    input  logic clr,
    input  logic rd_req,
    input  logic wr_req,
    input  logic mem_ready,
    output logic MARin,
    output logic MDRin,
    output logic Read,
    output logic Write,
    output logic mem_en,
    output logic busy,
    output logic done,
    output logic err
);

    state_e state_q, state_d;
    logic   op_rd_q;
    ctrl_t  ctrl_q;
    logic   expired;

    // The counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..256");
    end

`ifdef MEM_TIMEOUT_EN
    logic in_wait;
    logic err_q;

    assign in_wait = (state_q == StRdWait) || (state_q == StWrWait);

    wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .clr     (clr),
        .clear   (state_q == StAddr),
        .count_en(in_wait),
        .expired (expired)
    );

    // A ready strobe on the last allowed cycle completes normally.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_q <= 1'b0;
        end else begin
            err_q <= in_wait && expired && !mem_ready;
        end
    end

    assign err = err_q;
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (rd_req || wr_req) state_d = StAddr;
            StAddr:    state_d = op_rd_q ? StRdWait : StWrWait;
            StRdWait: begin
                if (mem_ready)    state_d = StRdLatch;
                else if (expired) state_d = StDone;
            end
            StRdLatch: state_d = StDone;
            StWrWait:  if (mem_ready || expired) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs are registered alongside the state so they never see the inputs directly.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            op_rd_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d);
            if (state_q == StIdle) op_rd_q <= rd_req;
        end
    end

    assign MARin  = ctrl_q.mar_in;
    assign MDRin  = ctrl_q.mdr_in;
    assign Read   = ctrl_q.read;
    assign Write  = ctrl_q.write;
    assign mem_en = ctrl_q.mem_en;
    assign busy   = ctrl_q.busy;
    assign done   = ctrl_q.done;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver pushes each transaction's expected
// profile (latency and per-strobe cycle counts), the monitor pops and compares on done.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic clr, rd_req, wr_req, mem_ready;
    logic MARin, MDRin, Read, Write, mem_en, busy, done, err;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .mem_ready(mem_ready),
        .MARin    (MARin),
        .MDRin    (MDRin),
        .Read     (Read),
        .Write    (Write),
        .mem_en   (mem_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat;
        int n_mar;
        int n_rd;
        int n_wr;
        int n_mdr;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int outs_now();
        return int'({MARin, MDRin, Read, Write, mem_en, busy, done, err});
    endfunction

    // Monitor: tallies strobes over each busy period and checks them when done appears.
    int   m_lat, m_mar, m_rd, m_wr, m_mdr;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!clr) begin
            m_lat = 0; m_mar = 0; m_rd = 0; m_wr = 0; m_mdr = 0;
        end else if (busy) begin
            m_lat++;
            m_mar += int'(MARin);
            m_rd  += int'(Read);
            m_wr  += int'(Write);
            m_mdr += int'(MDRin);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done actual=1 required=0 at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency", m_lat, mon_e.lat);
                    chk("marin_cycles", m_mar, mon_e.n_mar);
                    chk("read_cycles", m_rd, mon_e.n_rd);
                    chk("write_cycles", m_wr, mon_e.n_wr);
                    chk("mdrin_cycles", m_mdr, mon_e.n_mdr);
                    chk("err_flag", int'(err), mon_e.err);
                end
                m_lat = 0; m_mar = 0; m_rd = 0; m_wr = 0; m_mdr = 0;
            end
        end else begin
            chk("idle_outputs_zero", outs_now(), 0);
        end
    end

    // Call at a negedge. w = wait cycles; ready_at_end = 0 means memory never answers.
    task automatic run_txn(input bit rd, input bit wr, input int w, input bit ready_at_end);
        exp_t e;
        bit   is_rd;
        is_rd = rd;
        if (is_rd) begin
            if (ready_at_end) e = '{lat: w + 3, n_mar: 1, n_rd: w + 1, n_wr: 0, n_mdr: 1, err: 0};
            else              e = '{lat: w + 2, n_mar: 1, n_rd: w, n_wr: 0, n_mdr: 0, err: 1};
        end else begin
            e = '{lat: w + 2, n_mar: 1, n_rd: 0, n_wr: w, n_mdr: 0, err: ready_at_end ? 0 : 1};
        end
        exp_q.push_back(e);
        rd_req    = rd;
        wr_req    = wr;
        mem_ready = 1'($urandom);
        @(posedge clk);
        for (int c = 1; c <= e.lat; c++) begin
            @(negedge clk);
            rd_req = 1'($urandom);
            wr_req = 1'($urandom);
            if (c >= 2 && c <= 1 + w) mem_ready = (c == 1 + w) && ready_at_end;
            else                      mem_ready = 1'($urandom);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd_req    = 1'b0;
            wr_req    = 1'b0;
            mem_ready = rdy;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clr       = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", outs_now(), 0);
        #1 clr = 1'b1;
        idle(2, 1'b0);

        @(negedge clk); run_txn(1'b1, 1'b0, 1, 1'b1);   // minimum read
        @(negedge clk); run_txn(1'b0, 1'b1, 4, 1'b1);   // write, ready 3 cycles late
        @(negedge clk); run_txn(1'b1, 1'b1, 1, 1'b1);   // both requests: read wins
        idle(3, 1'b1);                                  // ready held high while idle
        @(negedge clk); run_txn(1'b1, 1'b0, 1, 1'b1);
        idle(2, 1'b0);

        // Abort mid-read with clr, then a request right at release.
        @(negedge clk);
        rd_req = 1'b1; wr_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); rd_req = 1'b0;
        @(negedge clk);
        chk("in_rd_wait_before_clr", int'(Read && mem_en && busy), 1);
        #2 clr = 1'b0;
        #1 chk("clr_async_outputs", outs_now(), 0);
        @(posedge clk);
        #1 chk("clr_held_outputs", outs_now(), 0);
        @(negedge clk);
        #1 clr = 1'b1;
        run_txn(1'b1, 1'b0, 2, 1'b1);

`ifdef MEM_TIMEOUT_EN
        @(negedge clk); run_txn(1'b1, 1'b0, 16, 1'b0);  // read timeout
        @(negedge clk); run_txn(1'b0, 1'b1, 16, 1'b0);  // write timeout
        @(negedge clk); run_txn(1'b1, 1'b0, 16, 1'b1);  // ready on the timeout cycle wins
        @(negedge clk); run_txn(1'b0, 1'b1, 16, 1'b1);
`endif

        for (int t = 0; t < 40; t++) begin
            int  op;
            bit  r, wq;
            op = int'($urandom_range(0, 2));
            r  = (op != 1);
            wq = (op != 0);
            idle(int'($urandom_range(0, 2)), 1'($urandom));
            @(negedge clk);
            run_txn(r, wq, int'($urandom_range(1, 10)), 1'b1);
        end

        idle(6, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
